mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//   Two-master arbiter/sequencer in front of the 512x16 single-port synchronous memory.
//   Accepts instruction-fetch (IF, read-only) and load/store (LS) requests.
//   Grants one request per slot and drives the memory's we/addr/din.
//   Hides the memory's 1-cycle read latency and returns registered read data per master.
// PARAMETERS
//   AW          9   address width; must match memory AW
//   DW          16  data width; must match memory DW
//   STARVE_MAX  4   consecutive LS grants allowed while if_req pending; range 1..15
// PORTS
//   clk        in   1   clock, rising edge
//   rst_b      in   1   asynchronous reset, active-low
//   if_req     in   1   fetch read request; held with if_addr until if_gnt
//   if_addr    in   AW  fetch address
//   if_gnt     out  1   1-cycle pulse: fetch request accepted this cycle
//   if_rvalid  out  1   1-cycle pulse: if_rdata valid
//   if_rdata   out  DW  fetch read data; holds until the next fetch response
//   ls_req     in   1   load/store request; held with ls_we/ls_addr/ls_wdata until ls_gnt
//   ls_we      in   1   1 = store, 0 = load
//   ls_addr    in   AW  load/store address
//   ls_wdata   in   DW  store data
//   ls_gnt     out  1   1-cycle pulse: LS request accepted this cycle
//   ls_rvalid  out  1   1-cycle pulse, loads only: ls_rdata valid
//   ls_rdata   out  DW  load data; holds until the next load response
//   mem_we     out  1   memory write enable
//   mem_addr   out  AW  memory address
//   mem_din    out  DW  memory write data
//   mem_dout   in   DW  memory read data; valid the cycle after mem_addr is sampled
//   busy       out  1   1 whenever state != IDLE
// BEHAVIOUR
//   Reset (rst_b low, async): state=IDLE; rvalids=0; rdatas=0; starve_cnt=0; owner=LS; last_addr=0.
//   Reset forces all combinational outputs (gnts, mem_we) to 0. mem_addr=0, mem_din=0.
//   FSM states: IDLE, RD_WAIT, RESP. Grants issue only in IDLE.
//   IDLE, no request: gnts=0, mem_we=0, mem_addr=last_addr, mem_din=0.
//   IDLE, winner present:
//     - Assert the winner's gnt combinationally in the same cycle (cycle N).
//     - Drive the winner's mem_addr; for an LS store, also drive mem_din and mem_we=1.
//     - Update last_addr from mem_addr on the clock edge.
//   Store: stay in IDLE. The next grant can issue at N+1, so back-to-back stores run 1/cycle.
//   Load or fetch: go to RD_WAIT at N+1.
//     - At the end of N+1, capture mem_dout into the owner's rdata.
//     - Go to RESP at N+2: owner's rvalid=1, then return to IDLE.
//     - The next grant issues no earlier than N+3.
//   mem_dout after a store cycle is ignored; the memory returns old data then.
//   Arbitration: LS has priority over IF.
//     - starve_cnt increments on each LS grant made while if_req=1.
//     - starve_cnt clears on any IF grant, and in any IDLE cycle with if_req=0.
//     - When starve_cnt==STARVE_MAX and if_req=1, IF wins over LS.
//   owner is registered at grant time and selects the rdata/rvalid target. Masters never receive each other's data.
//   A request dropped before its gnt is a protocol violation and is not detected.
//   Reset mid-read (in RD_WAIT or RESP): the pending response is discarded. No rvalid ever appears for it.
//   Address wrap: none; AW bits are passed through unmodified.
// TESTING
//   1. LS store 0x1A5<-0xBEEF -> ls_gnt, mem_we=1, mem_addr=0x1A5, mem_din=0xBEEF in the same cycle; no ls_rvalid; busy=0.
//   2. LS load 0x1A5 after test 1 -> ls_gnt at N, busy=1 at N+1..N+2, ls_rvalid=1 with ls_rdata=0xBEEF at N+2.
//   3. Fetch 0x010 (holds 0x1234) and LS load 0x020 (holds 0x5678), both requested at N:
//      ls_gnt at N, ls_rdata=0x5678 at N+2, if_gnt at N+3, if_rdata=0x1234 at N+5.
//   4. Continuous LS stores with if_req held: exactly 4 ls_gnt, then if_gnt; starve_cnt returns to 0.
//   5. rst_b low while in RD_WAIT: outputs go to 0 immediately, no rvalid afterwards, state=IDLE after release.
//   6. 8 back-to-back LS stores to 0x000..0x007: ls_gnt high 8 consecutive cycles; memory readback matches.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Two-master arbiter/sequencer in front of a single-port synchronous memory
//   with a 1-cycle read latency. Instruction fetch (IF, read-only) and
//   load/store (LS) requests are granted one per slot from IDLE. LS has
//   priority, but IF is forced through after STARVE_MAX consecutive LS grants
//   made while IF was waiting. Read data is registered per master.
//
// Ports
//   clk, rst_b                 clock (rising edge), async active-low reset
//   if_req/if_addr             fetch request, held until if_gnt
//   if_gnt                     fetch accepted this cycle (pulse)
//   if_rvalid/if_rdata         fetch response pulse / held read data
//   ls_req/ls_we/ls_addr/ls_wdata  load/store request, held until ls_gnt
//   ls_gnt                     load/store accepted this cycle (pulse)
//   ls_rvalid/ls_rdata         load response pulse / held read data
//   mem_we/mem_addr/mem_din    memory command
//   mem_dout                   memory read data, valid the cycle after addr
//   busy                       sequencer not in IDLE
module mem_access_ctrl #(
   parameter int unsigned AW         = 9,
   parameter int unsigned DW         = 16,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          ls_req,
   input  logic          ls_we,
   input  logic [AW-1:0] ls_addr,
   input  logic [DW-1:0] ls_wdata,
   output logic          ls_gnt,
   output logic          ls_rvalid,
   output logic [DW-1:0] ls_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
   typedef enum logic       {OWN_LS, OWN_IF}     owner_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t        state, state_nxt;
   owner_t        owner, owner_nxt;
   logic [3:0]    starve_cnt, starve_nxt;
   logic [AW-1:0] last_addr;
   logic          if_win;

   // IF wins only when LS is idle or LS has used up its starvation budget.
   assign if_win = if_req && (!ls_req || (starve_cnt == STARVE_LIM));
   assign busy   = (state != IDLE);

   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      starve_nxt = starve_cnt;
      if_gnt     = 1'b0;
      ls_gnt     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = last_addr;
      mem_din    = '0;
      case (state)
         IDLE: begin
            if (if_win) begin
               if_gnt     = 1'b1;
               mem_addr   = if_addr;
               owner_nxt  = OWN_IF;
               state_nxt  = RD_WAIT;
               starve_nxt = '0;
            end else if (ls_req) begin
               ls_gnt     = 1'b1;
               mem_addr   = ls_addr;
               owner_nxt  = OWN_LS;
               starve_nxt = if_req ? starve_cnt + 4'd1 : '0;
               if (ls_we) begin
                  mem_we  = 1'b1;
                  mem_din = ls_wdata;
               end else begin
                  state_nxt = RD_WAIT;
               end
            end else begin
               // No winner implies if_req is low here.
               starve_nxt = '0;
            end
         end
         RD_WAIT: state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // Combinational outputs are held quiet while reset is asserted.
      if (!rst_b) begin
         if_gnt   = 1'b0;
         ls_gnt   = 1'b0;
         mem_we   = 1'b0;
         mem_addr = '0;
         mem_din  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state      <= IDLE;
         owner      <= OWN_LS;
         starve_cnt <= '0;
         last_addr  <= '0;
         if_rvalid  <= 1'b0;
         ls_rvalid  <= 1'b0;
         if_rdata   <= '0;
         ls_rdata   <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         starve_cnt <= starve_nxt;
         last_addr  <= mem_addr;
         if_rvalid  <= (state == RD_WAIT) && (owner == OWN_IF);
         ls_rvalid  <= (state == RD_WAIT) && (owner == OWN_LS);
         if (state == RD_WAIT) begin
            if (owner == OWN_IF) if_rdata <= mem_dout;
            else                 ls_rdata <= mem_dout;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Bench for mem_access_ctrl with a read-first 512x16 synchronous memory
//   model. A cycle-by-cycle vector table covers store, load and contended
//   load/fetch; hand sequences cover starvation, back-to-back stores with
//   readback, and reset during a read.
module tb_mem_access_ctrl;
   localparam int unsigned AW = 9;
   localparam int unsigned DW = 16;

   logic          clk = 1'b0;
   logic          rst_b = 1'b0;
   logic          if_req, ls_req, ls_we;
   logic [AW-1:0] if_addr, ls_addr;
   logic [DW-1:0] ls_wdata;
   logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_we, busy;
   logic [DW-1:0] if_rdata, ls_rdata, mem_din;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dout;
   logic [DW-1:0] mem [0:511];

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   // Read-first memory: a store cycle returns the old contents.
   always @(posedge clk) begin
      if (!rst_b) begin
         mem[9'h010] <= 16'h1234;
         mem[9'h020] <= 16'h5678;
         mem[9'h030] <= 16'h0C0C;
      end else begin
         if (mem_we) mem[mem_addr] <= mem_din;
         mem_dout <= mem[mem_addr];
      end
   end

   mem_access_ctrl #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
      .clk(clk), .rst_b(rst_b),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .busy(busy)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic ls_req; logic ls_we; logic [8:0] ls_addr; logic [15:0] ls_wdata;
      logic if_req; logic [8:0] if_addr;
      logic gl; logic gi; logic we; logic [8:0] addr; logic [15:0] din;
      logic busy; logic lrv; logic [15:0] lrd; logic irv; logic [15:0] ird;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      // ls_req ls_we ls_addr ls_wdata if_req if_addr | gl gi we addr din busy lrv lrd irv ird
      vecs[0]  = '{1'b0,1'b0,9'h000,16'h0000,1'b0,9'h000, 1'b0,1'b0,1'b0,9'h000,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000};
      vecs[1]  = '{1'b1,1'b1,9'h1A5,16'hBEEF,1'b0,9'h000, 1'b1,1'b0,1'b1,9'h1A5,16'hBEEF,1'b0,1'b0,16'h0000,1'b0,16'h0000};
      vecs[2]  = '{1'b1,1'b0,9'h1A5,16'h0000,1'b0,9'h000, 1'b1,1'b0,1'b0,9'h1A5,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000};
      vecs[3]  = '{1'b0,1'b0,9'h000,16'h0000,1'b0,9'h000, 1'b0,1'b0,1'b0,9'h1A5,16'h0000,1'b1,1'b0,16'h0000,1'b0,16'h0000};
      vecs[4]  = '{1'b0,1'b0,9'h000,16'h0000,1'b0,9'h000, 1'b0,1'b0,1'b0,9'h1A5,16'h0000,1'b1,1'b1,16'hBEEF,1'b0,16'h0000};
      vecs[5]  = '{1'b0,1'b0,9'h000,16'h0000,1'b0,9'h000, 1'b0,1'b0,1'b0,9'h1A5,16'h0000,1'b0,1'b0,16'hBEEF,1'b0,16'h0000};
      vecs[6]  = '{1'b1,1'b0,9'h020,16'h0000,1'b1,9'h010, 1'b1,1'b0,1'b0,9'h020,16'h0000,1'b0,1'b0,16'hBEEF,1'b0,16'h0000};
      vecs[7]  = '{1'b0,1'b0,9'h000,16'h0000,1'b1,9'h010, 1'b0,1'b0,1'b0,9'h020,16'h0000,1'b1,1'b0,16'hBEEF,1'b0,16'h0000};
      vecs[8]  = '{1'b0,1'b0,9'h000,16'h0000,1'b1,9'h010, 1'b0,1'b0,1'b0,9'h020,16'h0000,1'b1,1'b1,16'h5678,1'b0,16'h0000};
      vecs[9]  = '{1'b0,1'b0,9'h000,16'h0000,1'b1,9'h010, 1'b0,1'b1,1'b0,9'h010,16'h0000,1'b0,1'b0,16'h5678,1'b0,16'h0000};
      vecs[10] = '{1'b0,1'b0,9'h000,16'h0000,1'b0,9'h000, 1'b0,1'b0,1'b0,9'h010,16'h0000,1'b1,1'b0,16'h5678,1'b0,16'h0000};
      vecs[11] = '{1'b0,1'b0,9'h000,16'h0000,1'b0,9'h000, 1'b0,1'b0,1'b0,9'h010,16'h0000,1'b1,1'b0,16'h5678,1'b1,16'h1234};
      vecs[12] = '{1'b0,1'b0,9'h000,16'h0000,1'b0,9'h000, 1'b0,1'b0,1'b0,9'h010,16'h0000,1'b0,1'b0,16'h5678,1'b0,16'h1234};

      if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      n_vec++;
      check("rst_busy", 16'(busy), 16'h0);
      check("rst_ls_rvalid", 16'(ls_rvalid), 16'h0);
      check("rst_if_rvalid", 16'(if_rvalid), 16'h0);
      check("rst_mem_addr", 16'(mem_addr), 16'h0);
      check("rst_ls_rdata", ls_rdata, 16'h0);
      check("rst_if_rdata", if_rdata, 16'h0);
      @(negedge clk);
      rst_b = 1'b1;

      // Cycle-accurate vector table
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         ls_req = vecs[i].ls_req; ls_we = vecs[i].ls_we;
         ls_addr = vecs[i].ls_addr; ls_wdata = vecs[i].ls_wdata;
         if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
         #1;
         n_vec++;
         check($sformatf("v%0d_ls_gnt", i), 16'(ls_gnt), 16'(vecs[i].gl));
         check($sformatf("v%0d_if_gnt", i), 16'(if_gnt), 16'(vecs[i].gi));
         check($sformatf("v%0d_mem_we", i), 16'(mem_we), 16'(vecs[i].we));
         check($sformatf("v%0d_mem_addr", i), 16'(mem_addr), 16'(vecs[i].addr));
         check($sformatf("v%0d_mem_din", i), mem_din, vecs[i].din);
         check($sformatf("v%0d_busy", i), 16'(busy), 16'(vecs[i].busy));
         check($sformatf("v%0d_ls_rvalid", i), 16'(ls_rvalid), 16'(vecs[i].lrv));
         check($sformatf("v%0d_ls_rdata", i), ls_rdata, vecs[i].lrd);
         check($sformatf("v%0d_if_rvalid", i), 16'(if_rvalid), 16'(vecs[i].irv));
         check($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].ird);
      end

      // Starvation: LS stores with fetch held; 4 LS grants then IF, twice
      begin
         int lcount = 0;
         int ifs = 0;
         logic [8:0] a = 9'h100;
         if_req = 1'b1; if_addr = 9'h030;
         for (int c = 0; c < 40 && ifs < 2; c++) begin
            @(negedge clk);
            ls_req = 1'b1; ls_we = 1'b1; ls_addr = a; ls_wdata = {7'h00, a} ^ 16'hA5A5;
            #1;
            if (ls_gnt && if_gnt) begin
               n_vec++;
               check("starve_dual_gnt", 16'h1, 16'h0);
            end
            if (ls_gnt) begin
               lcount++;
               a = a + 9'd1;
            end
            if (if_gnt) begin
               n_vec++;
               check($sformatf("starve_ls_run%0d", ifs), 16'(lcount), 16'd4);
               lcount = 0;
               ifs++;
            end
         end
         n_vec++;
         check("starve_if_grants", 16'(ifs), 16'd2);
         @(negedge clk);
         if_req = 1'b0; ls_req = 1'b0;
         @(negedge clk);
         #1;
         n_vec++;
         check("starve_if_rvalid", 16'(if_rvalid), 16'h1);
         check("starve_if_rdata", if_rdata, 16'h0C0C);
         check("starve_ls_rvalid", 16'(ls_rvalid), 16'h0);
      end

      // Back-to-back stores to 0x000..0x007
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ls_req = 1'b1; ls_we = 1'b1; ls_addr = 9'(i); ls_wdata = 16'h1000 + 16'(i);
         #1;
         n_vec++;
         check($sformatf("b2b_gnt%0d", i), 16'(ls_gnt), 16'h1);
         check($sformatf("b2b_addr%0d", i), 16'(mem_addr), 16'(i));
         check($sformatf("b2b_busy%0d", i), 16'(busy), 16'h0);
      end
      @(negedge clk);
      ls_req = 1'b0;

      // Readback through LS loads
      for (int i = 0; i < 8; i++) begin
         logic got;
         got = 1'b0;
         @(negedge clk);
         ls_req = 1'b1; ls_we = 1'b0; ls_addr = 9'(i);
         #1;
         n_vec++;
         check($sformatf("rb_gnt%0d", i), 16'(ls_gnt), 16'h1);
         for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            ls_req = 1'b0;
            #1;
            if (ls_rvalid) got = 1'b1;
         end
         n_vec++;
         check($sformatf("rb_valid%0d", i), 16'(got), 16'h1);
         if (got) check($sformatf("rb_data%0d", i), ls_rdata, 16'h1000 + 16'(i));
      end

      // Reset while in RD_WAIT
      @(negedge clk);
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 9'h003;
      #1;
      n_vec++;
      check("rr_gnt", 16'(ls_gnt), 16'h1);
      @(negedge clk);
      ls_req = 1'b0;
      #1;
      check("rr_busy_rdwait", 16'(busy), 16'h1);
      #2;
      rst_b = 1'b0;
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 9'h1FF; ls_wdata = 16'hFFFF; if_req = 1'b1; if_addr = 9'h1FF;
      #1;
      n_vec++;
      check("rr_ls_gnt", 16'(ls_gnt), 16'h0);
      check("rr_if_gnt", 16'(if_gnt), 16'h0);
      check("rr_mem_we", 16'(mem_we), 16'h0);
      check("rr_mem_addr", 16'(mem_addr), 16'h0);
      check("rr_mem_din", mem_din, 16'h0);
      check("rr_busy", 16'(busy), 16'h0);
      check("rr_ls_rvalid", 16'(ls_rvalid), 16'h0);
      check("rr_ls_rdata", ls_rdata, 16'h0);
      check("rr_if_rdata", if_rdata, 16'h0);
      @(negedge clk);
      rst_b = 1'b1; ls_req = 1'b0; if_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         n_vec++;
         check($sformatf("rr_post_ls_rvalid%0d", k), 16'(ls_rvalid), 16'h0);
         check($sformatf("rr_post_if_rvalid%0d", k), 16'(if_rvalid), 16'h0);
         check($sformatf("rr_post_busy%0d", k), 16'(busy), 16'h0);
      end
      @(negedge clk);
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 9'h055; ls_wdata = 16'h00AA;
      #1;
      n_vec++;
      check("rr_idle_gnt", 16'(ls_gnt), 16'h1);
      check("rr_idle_we", 16'(mem_we), 16'h1);
      @(negedge clk);
      ls_req = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
